// File: rtl/align_add_mantissas_if.sv
// Operand-in / significand-out bundle between the arrange stage, this align/add stage and normalisation.
// master = upstream/downstream environment, slave = the align/add stage.
interface align_add_mantissas_if #(
   parameter int MAN_W = 10,
   parameter int EXP_W = 5,
   parameter int GRS_W = 3
);
   localparam int EXT_W = 1 + MAN_W + GRS_W;

   logic             in_valid;
   logic             in_ready;
   logic             As;
   logic             Bs;
   logic             swap;
   logic [EXP_W-1:0] moves;
   logic [EXP_W-1:0] exp;
   logic [MAN_W-1:0] Am;
   logic [MAN_W-1:0] Bm;
   logic             out_valid;
   logic             out_ready;
   logic             out_sign;
   logic [EXP_W-1:0] out_exp;
   logic [EXT_W:0]   out_sum;

   modport master (
      output in_valid, As, Bs, swap, moves, exp, Am, Bm, out_ready,
      input  in_ready, out_valid, out_sign, out_exp, out_sum
   );

   modport slave (
      input  in_valid, As, Bs, swap, moves, exp, Am, Bm, out_ready,
      output in_ready, out_valid, out_sign, out_exp, out_sum
   );
endinterface

// File: rtl/align_add_mantissas.sv
// Restores hidden bits, right-aligns Bm one bit per clock with sticky, then adds/subtracts; valid min(moves,14)+1 clocks after accept.
// One operand set in flight: in_ready only in IDLE, result held in DONE until out_ready.
module align_add_mantissas #(
   parameter int MAN_W = 10,
   parameter int EXP_W = 5,
   parameter int GRS_W = 3
) (
   input logic                  clk,
   input logic                  rst_n,
   align_add_mantissas_if.slave io
);
   localparam int EXT_W = 1 + MAN_W + GRS_W;
   localparam int CNT_W = $clog2(EXT_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(EXT_W);
   localparam logic [EXP_W-1:0] MOVES_MAX = EXP_W'(EXT_W);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_ADD,
      ST_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [EXT_W-1:0]   a_ext_q, a_ext_d;
   logic [EXT_W-1:0]   b_ext_q, b_ext_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               eff_sub_q, eff_sub_d;
   logic               res_sign_q, res_sign_d;
   logic [EXP_W-1:0]   exp_q, exp_d;
   logic               out_sign_q, out_sign_d;
   logic [EXP_W-1:0]   out_exp_q, out_exp_d;
   logic [EXT_W:0]     out_sum_q, out_sum_d;
   logic [EXT_W:0]     sum_w;

   always_comb begin
      state_d    = state_q;
      a_ext_d    = a_ext_q;
      b_ext_d    = b_ext_q;
      cnt_d      = cnt_q;
      eff_sub_d  = eff_sub_q;
      res_sign_d = res_sign_q;
      exp_d      = exp_q;
      out_sign_d = out_sign_q;
      out_exp_d  = out_exp_q;
      out_sum_d  = out_sum_q;
      sum_w      = eff_sub_q ? ({1'b0, a_ext_q} - {1'b0, b_ext_q})
                             : ({1'b0, a_ext_q} + {1'b0, b_ext_q});

      unique case (state_q)
         ST_IDLE: begin
            if (io.in_valid) begin
               // B's hidden bit is clear exactly when B is subnormal, i.e. its own exponent exp-moves is 0
               a_ext_d    = {io.exp != '0, io.Am, {GRS_W{1'b0}}};
               b_ext_d    = {io.exp != io.moves, io.Bm, {GRS_W{1'b0}}};
               cnt_d      = (io.moves >= MOVES_MAX) ? CNT_MAX : CNT_W'(io.moves);
               eff_sub_d  = io.As ^ io.Bs;
               res_sign_d = io.swap ? io.Bs : io.As;
               exp_d      = io.exp;
               state_d    = (cnt_d != '0) ? ST_SHIFT : ST_ADD;
            end
         end
         ST_SHIFT: begin
            b_ext_d    = {1'b0, b_ext_q[EXT_W-1:1]};
            b_ext_d[0] = b_ext_q[1] | b_ext_q[0];
            cnt_d      = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_ADD;
            end
         end
         ST_ADD: begin
            out_sum_d  = sum_w;
            out_exp_d  = exp_q;
            out_sign_d = res_sign_q & ~(eff_sub_q & (sum_w == '0));
            state_d    = ST_DONE;
         end
         ST_DONE: begin
            if (io.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         a_ext_q    <= '0;
         b_ext_q    <= '0;
         cnt_q      <= '0;
         eff_sub_q  <= 1'b0;
         res_sign_q <= 1'b0;
         exp_q      <= '0;
         out_sign_q <= 1'b0;
         out_exp_q  <= '0;
         out_sum_q  <= '0;
      end else begin
         state_q    <= state_d;
         a_ext_q    <= a_ext_d;
         b_ext_q    <= b_ext_d;
         cnt_q      <= cnt_d;
         eff_sub_q  <= eff_sub_d;
         res_sign_q <= res_sign_d;
         exp_q      <= exp_d;
         out_sign_q <= out_sign_d;
         out_exp_q  <= out_exp_d;
         out_sum_q  <= out_sum_d;
      end
   end

   assign io.in_ready  = (state_q == ST_IDLE);
   assign io.out_valid = (state_q == ST_DONE);
   assign io.out_sign  = out_sign_q;
   assign io.out_exp   = out_exp_q;
   assign io.out_sum   = out_sum_q;
endmodule

// File: tb/tb_align_add_mantissas.sv
// Directed bench for align_add_mantissas: arithmetic reference model plus literal expectations.
module tb_align_add_mantissas;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   align_add_mantissas_if bus ();
   align_add_mantissas dut (.clk(clk), .rst_n(rst_n), .io(bus));

   typedef struct {
      logic [14:0] sum;
      logic        sign;
      logic [4:0]  e;
      int          n;
      int          acc;
      bit          seen;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: align by plain integer shift, sticky = any bit shifted out.
   function automatic exp_t model(input logic [4:0] e, input logic [4:0] mv,
                                  input logic [9:0] am, input logic [9:0] bm,
                                  input logic as_, input logic bs_, input logic sw);
      exp_t r;
      int a, b, n, bsh, s;
      a   = ((e != 0) ? 8192 : 0) + int'(am) * 8;
      b   = ((e != mv) ? 8192 : 0) + int'(bm) * 8;
      n   = (int'(mv) > 14) ? 14 : int'(mv);
      bsh = (b >> n) | (((b % (1 << n)) != 0) ? 1 : 0);
      s   = (as_ ^ bs_) ? (a - bsh) : (a + bsh);
      r.sum  = s[14:0];
      r.sign = sw ? bs_ : as_;
      if ((as_ ^ bs_) && (s == 0)) r.sign = 1'b0;
      r.e    = e;
      r.n    = n;
      r.acc  = 0;
      r.seen = 1'b0;
      return r;
   endfunction

   // Compare process: every negedge, outputs against the scoreboard head.
   always @(negedge clk) begin : cmp
      exp_t m;
      if (!rst_n) begin
         sb.delete();
      end else begin
         if (bus.in_valid && bus.in_ready) begin
            m = model(bus.exp, bus.moves, bus.Am, bus.Bm, bus.As, bus.Bs, bus.swap);
            m.acc = cyc + 1;
            sb.push_back(m);
         end
         if (sb.size() == 0) begin
            check("spurious_valid", bus.out_valid, 1'b0);
         end else if (bus.out_valid) begin
            if (!sb[0].seen) begin
               check("latency", cyc - sb[0].acc, sb[0].n + 1);
               sb[0].seen = 1'b1;
            end
            check("out_sum", bus.out_sum, sb[0].sum);
            check("out_sign", bus.out_sign, sb[0].sign);
            check("out_exp", bus.out_exp, sb[0].e);
            check("in_ready_busy", bus.in_ready, 1'b0);
            if (bus.out_ready) void'(sb.pop_front());
         end
      end
   end

   task automatic drive(input logic [4:0] e, input logic [4:0] mv, input logic [9:0] am,
                        input logic [9:0] bm, input logic as_, input logic bs_, input logic sw);
      bus.exp = e; bus.moves = mv; bus.Am = am; bus.Bm = bm;
      bus.As = as_; bus.Bs = bs_; bus.swap = sw;
      bus.in_valid = 1'b1;
   endtask

   task automatic send(input logic [4:0] e, input logic [4:0] mv, input logic [9:0] am,
                       input logic [9:0] bm, input logic as_, input logic bs_, input logic sw);
      int k = 0;
      drive(e, mv, am, bm, as_, bs_, sw);
      @(negedge clk);
      while (!bus.in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!bus.in_ready) check("accept_timeout", bus.in_ready, 1'b1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int k = 0;
      @(negedge clk);
      while (!bus.out_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (!bus.out_valid) check("valid_timeout", bus.out_valid, 1'b1);
   endtask

   task automatic run(input string name, input logic [4:0] e, input logic [4:0] mv,
                      input logic [9:0] am, input logic [9:0] bm, input logic as_,
                      input logic bs_, input logic sw, input logic [14:0] lit);
      send(e, mv, am, bm, as_, bs_, sw);
      wait_valid();
      check(name, bus.out_sum, lit);
      @(posedge clk);
      #1;
   endtask

   initial begin : drv
      exp_t m;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus.As = 1'b0; bus.Bs = 1'b0; bus.swap = 1'b0;
      bus.moves = '0; bus.exp = '0; bus.Am = '0; bus.Bm = '0;

      #2;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_sum", bus.out_sum, 15'h0);
      check("rst_out_sign", bus.out_sign, 1'b0);
      check("rst_out_exp", bus.out_exp, 5'd0);

      m = model(5'd15, 5'd0, 10'h0, 10'h0, 1'b0, 1'b0, 1'b0);
      check("model_1p1", m.sum, 15'h4000);
      m = model(5'd15, 5'd1, 10'h0, 10'h0, 1'b0, 1'b0, 1'b0);
      check("model_1p05", m.sum, 15'h3000);
      m = model(5'd30, 5'd20, 10'h0, 10'h1, 1'b0, 1'b0, 1'b0);
      check("model_big_add", m.sum, 15'h2001);
      m = model(5'd30, 5'd20, 10'h0, 10'h1, 1'b0, 1'b1, 1'b0);
      check("model_big_sub", m.sum, 15'h1FFF);
      m = model(5'd10, 5'd0, 10'h155, 10'h155, 1'b1, 1'b0, 1'b0);
      check("model_cancel_sign", m.sign, 1'b0);

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_in_ready", bus.in_ready, 1'b1);
      check("rel_out_valid", bus.out_valid, 1'b0);
      @(posedge clk);
      #1;

      run("one_plus_one",  5'd15, 5'd0,  10'h000, 10'h000, 1'b0, 1'b0, 1'b0, 15'h4000);
      run("one_plus_half", 5'd15, 5'd1,  10'h000, 10'h000, 1'b0, 1'b0, 1'b0, 15'h3000);
      run("clamp_add",     5'd30, 5'd20, 10'h000, 10'h001, 1'b0, 1'b0, 1'b0, 15'h2001);
      run("clamp_sub",     5'd30, 5'd20, 10'h000, 10'h001, 1'b0, 1'b1, 1'b0, 15'h1FFF);
      run("zero_cancel",   5'd0,  5'd0,  10'h000, 10'h000, 1'b0, 1'b1, 1'b0, 15'h0000);
      run("subnormal_b",   5'd5,  5'd5,  10'h000, 10'h200, 1'b0, 1'b0, 1'b0, 15'h2080);
      run("sub_swap",      5'd16, 5'd3,  10'h200, 10'h155, 1'b0, 1'b1, 1'b1, 15'h2AAB);
      run("moves_14",      5'd20, 5'd14, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 15'h3FF9);
      run("moves_13",      5'd20, 5'd13, 10'h000, 10'h000, 1'b0, 1'b0, 1'b0, 15'h2001);
      run("carry_out",     5'd10, 5'd0,  10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 15'h7FF0);
      run("cancel_nz_exp", 5'd10, 5'd0,  10'h155, 10'h155, 1'b1, 1'b0, 1'b0, 15'h0000);

      // Backpressure with a second set queued behind the stalled result
      bus.out_ready = 1'b0;
      send(5'd15, 5'd2, 10'h100, 10'h000, 1'b0, 1'b0, 1'b0);
      wait_valid();
      check("bp_sum", bus.out_sum, 15'h3000);
      #1 drive(5'd15, 5'd0, 10'h000, 10'h000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_in_ready", bus.in_ready, 1'b0);
         check("bp_valid_held", bus.out_valid, 1'b1);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(negedge clk);
      check("no_same_cycle_accept", bus.in_ready, 1'b0);
      @(negedge clk);
      check("bp_idle_ready", bus.in_ready, 1'b1);
      check("bp_idle_valid", bus.out_valid, 1'b0);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      wait_valid();
      check("bp_second_sum", bus.out_sum, 15'h4000);
      @(posedge clk);
      #1;

      // Reset in the middle of a 10-cycle shift
      send(5'd20, 5'd10, 10'h005, 10'h003, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      check("mid_shift_busy", bus.in_ready, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("abort_in_ready", bus.in_ready, 1'b1);
      check("abort_out_valid", bus.out_valid, 1'b0);
      check("abort_out_sum", bus.out_sum, 15'h0);
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_abort_ready", bus.in_ready, 1'b1);
      check("post_abort_valid", bus.out_valid, 1'b0);
      repeat (20) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/align_add_mantissas.md
Name: align_add_mantissas

Overview:
- Downstream stage of the half-precision operand-arrangement logic in the IEEE-754 adder datapath.
- Consumes the arranged operands: larger-magnitude mantissa Am, smaller mantissa Bm, signs, common exponent, shift distance `moves`, and the swap flag.
- Restores the hidden bits and right-aligns Bm iteratively, one bit per clock, while collecting guard/round/sticky bits.
- Performs the effective add or subtract and hands the raw 15-bit significand to the normalisation stage over a valid/ready handshake.

Parameters:
- MAN_W, 10, stored fraction width.
- EXP_W, 5, exponent width.
- GRS_W, 3, guard/round/sticky bits appended below the fraction.
- Derived: EXT_W = 1 + MAN_W + GRS_W = 14, the working significand width. It is also the maximum number of shift cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream operand set valid.
- in_ready  out  1  stage can accept an operand set.
- As  in  1  sign of operand A.
- Bs  in  1  sign of operand B.
- swap  in  1  operands were exchanged upstream.
- moves  in  EXP_W  exponent difference.
- exp  in  EXP_W  larger (common) exponent.
- Am  in  MAN_W  larger-magnitude fraction.
- Bm  in  MAN_W  smaller-magnitude fraction.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sign  out  1  result sign.
- out_exp  out  EXP_W  result exponent, equal to the latched exp.
- out_sum  out  EXT_W+1  raw significand; bit 14 = carry, bits 2:0 = G/R/S.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; out_valid=0, out_sign=0, out_exp=0, out_sum=0; all internal registers cleared. in_ready=1 once reset is released.
- in_ready = (state==IDLE). This is a combinational decode of the state register.
- Accept occurs on a rising edge with in_valid && in_ready. On accept, the stage latches:
  - A_ext = {hA, Am, 3'b000}, where hA = (exp != 0).
  - B_ext = {hB, Bm, 3'b000}, where hB = ((exp - moves) != 0).
  - cnt = min(moves, EXT_W).
  - eff_sub = As ^ Bs.
  - res_sign = swap ? Bs : As.
  - Next state = SHIFT if cnt != 0, else ADD.
- SHIFT state, each cycle:
  - B_ext shifts right by 1.
  - The new bit 0 is the OR of the old bit 1 and the old bit 0 (sticky accumulation).
  - cnt decrements.
  - When cnt==1, next state = ADD.
- moves >= EXT_W is clamped to 14 cycles. After the clamp, B_ext holds only the sticky bit (1 if Bm or hB was nonzero).
- ADD state, 1 cycle:
  - If eff_sub=0: out_sum = A_ext + B_ext.
  - If eff_sub=1: out_sum = A_ext - B_ext. Upstream guarantees A >= B, so no borrow occurs.
  - Also registers out_exp = exp and out_sign = res_sign. If eff_sub=1 and out_sum==0, out_sign is forced to 0.
  - Next state = DONE with out_valid=1.
- DONE state:
  - Outputs are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid=0 and next state = IDLE. The next operand set can then be accepted on the following edge (no same-cycle re-accept).
- Latency: out_valid rises N+1 clocks after the accept edge, where N = min(moves, 14). Range is 1 to 15 clocks.
- In SHIFT/ADD/DONE, inputs are ignored and in_valid is don't-care.
- Exact cancellation (upstream zeroes every field): the result is out_sum=0, out_sign=0, out_exp=0.
- Subnormal operands: exp=0 gives hA=0. Operand B is subnormal when exp==moves, which gives hB=0.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation immediately. No partial result is emitted after release.

Test Plan:
- 1.0+1.0: exp=15, Am=Bm=0, moves=0, As=Bs=0 -> out_sum=15'h4000, out_exp=15, out_sign=0, out_valid 1 clk after accept.
- 1.0+0.5: exp=15, moves=1, Am=Bm=0, same signs -> out_sum=15'h3000, out_valid 2 clks after accept.
- Large shift: exp=30, moves=20, Am=0, Bm=10'h001, As=Bs=0 -> exactly 14 SHIFT cycles; out_sum=15'h2001 (sticky only). With Bs=1 -> out_sum=15'h1FFF.
- Exact cancel: all inputs 0, As=0, Bs=1 -> out_sum=0, out_sign=0, out_exp=0.
- Backpressure: out_ready held low 5 clks after out_valid -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE on the next edge; a second set queued on in_valid is accepted one edge later.
- Reset mid-operation: pulse rst_n low during SHIFT with moves=10 -> out_valid=0 and in_ready=1 immediately after release; no result is ever emitted for that set.
